nios_interrupt_ocimem_monitor: RTL
==================================

# nios_interrupt_ocimem_monitor

Monitor-memory stage directly downstream of the CPU debug-slave sysclk logic. It consumes the `jdo` command word and the `take_action_ocimem_*` strobes, and performs JTAG-driven reads and writes into a 2^ADDR_W x 32 on-chip debug RAM. It returns `MonDReg`, `monitor_ready` and `monitor_error` back up to the debug slave. It also exposes the same RAM to the CPU through an Avalon-MM slave with waitrequest, and arbitrates between the two masters.

## Interface
- ADDR_W, 8, word-address width; RAM depth 2^ADDR_W, legal range 4..16.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  command/data word from the debug slave, valid in the cycle of any strobe.
- take_action_ocimem_a  in  1  one-cycle strobe: address load / read command.
- take_no_action_ocimem_a  in  1  one-cycle strobe: streaming read at current address.
- take_action_ocimem_b  in  1  one-cycle strobe: write `jdo[34:3]` at current address.
- MonDReg  out  32  last JTAG read data.
- monitor_ready  out  1  last JTAG request completed.
- monitor_error  out  1  sticky overrun flag.
- avs_address  in  ADDR_W  CPU word address.
- avs_read, avs_write  in  1  CPU read/write request, held until waitrequest is low.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU byte lanes.
- avs_readdata  out  32  CPU read data, valid when read=1 and waitrequest=0.
- avs_waitrequest  out  1  CPU stall.

## Operation
- **JTAG decode (strobe cycle), with jdo field meanings:**
  - `take_action_ocimem_a`:
    - `jdo[36]=1` clears monitor_error.
    - `jdo[35]=1` loads MonAReg <= `jdo[ADDR_W+1:2]`.
    - `jdo[34]=1` queues a read.
  - `take_no_action_ocimem_a`: queues a read.
  - `take_action_ocimem_b`: queues a write of `jdo[34:3]`, all byte lanes.
- **Pending register:** one entry (jpend, op, data), latched at the end of the strobe cycle. The address load and the error clear take effect immediately, even if jpend is set.
- **Overrun handling:**
  - A queuing strobe while jpend=1 is dropped and sets monitor_error.
  - Two queuing strobes in the same cycle: priority ocimem_a > no_action_a > ocimem_b; the loser sets monitor_error.
- **monitor_ready:** cleared when a request is latched; set when it completes.
- **MonAReg:** increments by 1 after every completed JTAG access; wraps from 2^ADDR_W-1 to 0.
- **FSM states:** IDLE, J_READ, C_READ.
  - IDLE with jpend, write: RAM written at MonAReg; jpend cleared; MonAReg incremented; stay IDLE.
  - IDLE with jpend, read: RAM addressed with MonAReg; go J_READ.
  - IDLE without jpend, avs_write: byte-enabled RAM write; zero wait states.
  - IDLE without jpend, avs_read: RAM addressed with avs_address; go C_READ.
  - J_READ: MonDReg <= RAM q; jpend cleared; MonAReg incremented; monitor_ready set; go IDLE.
  - C_READ: avs_readdata = RAM q; go IDLE.
- **avs_waitrequest:**
  - High in IDLE when (avs_read or jpend) and (avs_read or avs_write).
  - High in J_READ whenever (avs_read or avs_write) is asserted.
  - Low in C_READ.
  - High during reset.
- **Arbitration:** JTAG always wins. A CPU write never overlaps a JTAG write in the same cycle.
- **Reset (synchronous, including mid-operation):**
  - State returns to IDLE; jpend cleared.
  - MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, avs_readdata=0.
  - Any in-flight access is abandoned with no RAM write.
  - RAM contents are not cleared.

## Timing
- RAM is synchronous read with 1-cycle latency and write-first semantics.
- **JTAG read** (strobe in cycle 0):
  - RAM addressed in cycle 1.
  - MonDReg and monitor_ready=1 valid in cycle 3.
  - +1 cycle if a C_READ occupies cycle 1.
- **JTAG write** (strobe in cycle 0): RAM updated in cycle 1; monitor_ready=1 in cycle 2.
- **CPU read:** 1 wait state; data returned in the second cycle of the request.
- **CPU write:** 0 wait states when no JTAG request is pending.
- A CPU request coinciding with a pending JTAG request stalls exactly as long as that JTAG access takes.

## Test plan
- **Reset values:** assert reset for 2 cycles -> all outputs at reset values, avs_waitrequest=1 during reset, then 0 with no request.
- **JTAG write/read-back:**
  - ocimem_a with `jdo[35]=1`, address 0x10.
  - ocimem_b with data 0xDEADBEEF.
  - ocimem_a with `jdo[35]=1`, `jdo[34]=1`, address 0x10.
  - -> MonDReg=0xDEADBEEF three cycles after the last strobe, MonAReg=0x11.
- **Wrap and streaming:** load address 0xFF; 2x no_action_a -> reads of 0xFF then 0x00; MonAReg=0x01.
- **CPU access:**
  - CPU write 0x12345678 with byteenable 0b0011 over 0xFFFFFFFF at address 5 -> read returns 0xFFFF5678 with exactly 1 wait state.
  - JTAG read of address 5 returns the same value.
- **Contention:** CPU avs_read asserted in the same cycle jpend is set -> JTAG serviced first; CPU waitrequest low 2 cycles later with correct data.
- **Overrun/error:**
  - ocimem_b and no_action_a in the same cycle -> read queued, monitor_error=1.
  - ocimem_a with `jdo[36]=1` -> monitor_error=0.
  - Reset during J_READ -> MonDReg=0, monitor_ready=0, FSM in IDLE.

Source files
------------

// File: rtl/nios_interrupt_ocimem_monitor.sv
// JTAG/CPU shared on-chip debug RAM: decodes debug-slave ocimem strobes into one pending
// access and arbitrates it against an Avalon-MM slave port, with JTAG always winning.
module nios_interrupt_ocimem_monitor #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, J_READ, C_READ} state_t;

  state_t              state_q, state_d;
  logic                jpend_q, jpend_d;
  logic                jwr_q, jwr_d;
  logic [31:0]         jdata_q, jdata_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [31:0]         mon_d_q, mon_d_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

  logic [31:0]         mem [DEPTH];
  logic [31:0]         ram_q;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_wdata;
  logic [3:0]          ram_be;
  logic [31:0]         ram_merged;

  logic                q_a, q_n, q_b, any_q, multi_q;
  logic                unused_jdo;

  assign unused_jdo = ^{jdo[37], jdo[1:0]};

  assign q_a     = take_action_ocimem_a & jdo[34];
  assign q_n     = take_no_action_ocimem_a;
  assign q_b     = take_action_ocimem_b;
  assign any_q   = q_a | q_n | q_b;
  assign multi_q = (q_a & (q_n | q_b)) | (q_n & q_b);

  // Next-state, RAM port steering and strobe decode.
  always_comb begin
    state_d   = state_q;
    jpend_d   = jpend_q;
    jwr_d     = jwr_q;
    jdata_d   = jdata_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    ready_d   = ready_q;
    error_d   = error_q;
    ram_we    = 1'b0;
    ram_addr  = avs_address;
    ram_wdata = avs_writedata;
    ram_be    = avs_byteenable;

    unique case (state_q)
      IDLE: begin
        if (jpend_q) begin
          ram_addr = mon_a_q;
          if (jwr_q) begin
            ram_we    = 1'b1;
            ram_wdata = jdata_q;
            ram_be    = 4'hF;
            jpend_d   = 1'b0;
            mon_a_d   = mon_a_q + ADDR_W'(1);
            ready_d   = 1'b1;
          end else begin
            state_d = J_READ;
          end
        end else if (avs_read) begin
          state_d = C_READ;
        end else if (avs_write) begin
          ram_we = 1'b1;
        end
      end
      J_READ: begin
        mon_d_d = ram_q;
        jpend_d = 1'b0;
        mon_a_d = mon_a_q + ADDR_W'(1);
        ready_d = 1'b1;
        state_d = IDLE;
      end
      C_READ:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An address load overrides the completion increment in the same cycle.
    if (take_action_ocimem_a && jdo[35]) mon_a_d = jdo[ADDR_W+1:2];
    if (take_action_ocimem_a && jdo[36]) error_d = 1'b0;
    if (any_q && (jpend_q || multi_q))   error_d = 1'b1;

    if (any_q && !jpend_q) begin
      jpend_d = 1'b1;
      jwr_d   = !(q_a || q_n);
      jdata_d = jdo[34:3];
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      jpend_q <= 1'b0;
      jwr_q   <= 1'b0;
      jdata_q <= '0;
      mon_a_q <= '0;
      mon_d_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      jpend_q <= jpend_d;
      jwr_q   <= jwr_d;
      jdata_q <= jdata_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ram_merged[8*i +: 8] = ram_be[i] ? ram_wdata[8*i +: 8] : mem[ram_addr][8*i +: 8];
    end
  end

  // Write-first synchronous RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      mem[ram_addr] <= ram_merged;
      ram_q         <= ram_merged;
    end else begin
      ram_q <= mem[ram_addr];
    end
  end

  always_comb begin
    unique case (state_q)
      IDLE:    avs_waitrequest = (avs_read | jpend_q) & (avs_read | avs_write);
      J_READ:  avs_waitrequest = avs_read | avs_write;
      default: avs_waitrequest = 1'b0;
    endcase
    if (reset) avs_waitrequest = 1'b1;
  end

  assign avs_readdata  = (state_q == C_READ && !reset) ? ram_q : 32'h0;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule
